ram_dma: RTL and testbench



---
 rtl/ram_dma_pkg.sv | 16 +
 rtl/ram_if.sv | 18 +
 rtl/ram_dma.sv | 187 ++++++++++++++++++
 tb/tb_ram_dma.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_dma_pkg.sv
// Shared types for the RAM block-move engine: command mode and FSM state.
package ram_dma_pkg;

  typedef enum logic {
    DMA_COPY = 1'b0,
    DMA_FILL = 1'b1
  } dma_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dma_state_e;

endpackage

// File: rtl/ram_if.sv
// Port bundle of the true dual-port single-clock RAM.
// The sys modport is the master side driven by ram_dma; ram is the memory side.
interface ram_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          w_a;
  logic [AW-1:0] a_a;
  logic [DW-1:0] d_a;
  logic [DW-1:0] q_a;
  logic          w_b;
  logic [AW-1:0] a_b;
  logic [DW-1:0] d_b;
  logic [DW-1:0] q_b;

  modport sys (output w_a, a_a, d_a, w_b, a_b, d_b, input q_a, q_b);
  modport ram (input w_a, a_a, d_a, w_b, a_b, d_b, output q_a, q_b);
endinterface

// File: rtl/ram_dma.sv
// Block COPY (port A read -> port B write) / FILL (port B constant write)
// master for a true dual-port single-clock RAM with 1-cycle read latency.
// Optional macro RAM_DMA_CSUM_EN adds a csum output: XOR of all words
// written by the last accepted command.
//
// state | meaning
// IDLE  | waiting for start; rejects forward-overlapping COPY
// RD    | COPY: issue read on A (write of previous word on B); FILL: write on B
// DRAIN | COPY: final write of the word read in the last RD cycle
// DONE  | one-cycle completion, busy still high, start ignored
module ram_dma
  import ram_dma_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW:0]   len,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          w_a,
  output logic [AW-1:0] a_a,
  output logic [DW-1:0] d_a,
  input  logic [DW-1:0] q_a,
  output logic          w_b,
  output logic [AW-1:0] a_b,
  output logic [DW-1:0] d_b,
  input  logic [DW-1:0] q_b
`ifdef RAM_DMA_CSUM_EN
  ,
  output logic [DW-1:0] csum
`endif
);

  dma_state_e    state_q, state_d;
  dma_mode_e     mode_q;
  logic [DW-1:0] fill_q;
  logic [AW-1:0] dst_q;
  logic [AW-1:0] a_a_q;
  logic [AW-1:0] a_b_q;
  logic [AW:0]   rem_q;
  logic          w_b_q;
  logic          err_q;

  logic          busy_c;
  logic          done_c;
  logic [DW-1:0] d_b_c;
  logic [AW-1:0] offset;
  logic          len_zero;
  logic          reject;
  logic          last_word;
  logic          unused_q_b;

  ram_if #(.AW(AW), .DW(DW)) u_ram_if ();

  // A write to dst+j while port A still has to read src+i (i>j) collides
  // when dst-src falls in [1, len-1]; such COPY commands are refused.
  assign offset    = dst - src;
  assign len_zero  = (len == '0);
  assign reject    = (dma_mode_e'(mode) == DMA_COPY) && (offset != '0) &&
                     ({1'b0, offset} < len);
  assign last_word = (rem_q == (AW+1)'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_zero)     state_d = DONE;
          else if (!reject) state_d = RD;
        end
      end
      RD: begin
        if (last_word) state_d = (mode_q == DMA_COPY) ? DRAIN : DONE;
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status and write data; COPY data comes straight from the port A read.
  always_comb begin
    busy_c = (state_q != IDLE);
    done_c = (state_q == DONE);
    d_b_c  = (mode_q == DMA_FILL) ? fill_q : u_ram_if.q_a;
  end

  // Command latch, address/word counters and registered RAM controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= DMA_COPY;
      fill_q <= '0;
      dst_q  <= '0;
      a_a_q  <= '0;
      a_b_q  <= '0;
      rem_q  <= '0;
      w_b_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q <= dma_mode_e'(mode);
            fill_q <= fill_val;
            dst_q  <= dst;
            rem_q  <= len;
            if (reject) begin
              err_q <= 1'b1;
            end else if (!len_zero) begin
              if (dma_mode_e'(mode) == DMA_FILL) begin
                w_b_q <= 1'b1;
                a_b_q <= dst;
              end else begin
                a_a_q <= src;
              end
            end
          end
        end
        RD: begin
          rem_q <= rem_q - (AW+1)'(1);
          if (mode_q == DMA_COPY) begin
            w_b_q <= 1'b1;
            a_b_q <= w_b_q ? (a_b_q + AW'(1)) : dst_q;
            if (!last_word) a_a_q <= a_a_q + AW'(1);
          end else if (last_word) begin
            w_b_q <= 1'b0;
          end else begin
            a_b_q <= a_b_q + AW'(1);
          end
        end
        DRAIN:   w_b_q <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef RAM_DMA_CSUM_EN
  logic [DW-1:0] csum_q;

  // Fold every written word; restart on each accepted command.
  always_ff @(posedge clk) begin
    if (rst)                                         csum_q <= '0;
    else if (state_q == IDLE && start && !reject)    csum_q <= '0;
    else if (w_b_q)                                  csum_q <= csum_q ^ d_b_c;
  end

  assign csum = csum_q;
`endif

  assign u_ram_if.w_a = 1'b0;
  assign u_ram_if.a_a = a_a_q;
  assign u_ram_if.d_a = '0;
  assign u_ram_if.w_b = w_b_q;
  assign u_ram_if.a_b = a_b_q;
  assign u_ram_if.d_b = d_b_c;
  assign u_ram_if.q_a = q_a;
  assign u_ram_if.q_b = q_b;

  assign w_a  = u_ram_if.w_a;
  assign a_a  = u_ram_if.a_a;
  assign d_a  = u_ram_if.d_a;
  assign w_b  = u_ram_if.w_b;
  assign a_b  = u_ram_if.a_b;
  assign d_b  = u_ram_if.d_b;
  assign busy = busy_c;
  assign done = done_c;
  assign err  = err_q;

  assign unused_q_b = ^u_ram_if.q_b;

endmodule

// File: tb/tb_ram_dma.sv
// Self-checking bench for ram_dma: behavioural RAM plus a word-level model of
// what each command must do, cycle by cycle, derived from the command rules.
module tb_ram_dma;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] src = '0;
  logic [AW-1:0] dst = '0;
  logic [AW:0]   len = '0;
  logic [DW-1:0] fill_val = '0;
  logic          busy, done, err, w_a, w_b;
  logic [AW-1:0] a_a, a_b;
  logic [DW-1:0] d_a, d_b, q_a, q_b;
`ifdef RAM_DMA_CSUM_EN
  logic [DW-1:0] csum;
`endif

  logic [DW-1:0] mem [0:NW-1];
  logic [DW-1:0] mdl [0:NW-1];

  int n_cmp = 0;
  int n_fail = 0;

  ram_dma #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .busy(busy), .done(done), .err(err),
    .w_a(w_a), .a_a(a_a), .d_a(d_a), .q_a(q_a),
    .w_b(w_b), .a_b(a_b), .d_b(d_b), .q_b(q_b)
`ifdef RAM_DMA_CSUM_EN
    , .csum(csum)
`endif
  );

  always #5 clk = ~clk;

  // True dual-port single-clock RAM, registered read.
  always @(posedge clk) begin
    q_a <= mem[a_a];
    q_b <= mem[a_b];
    if (w_a) mem[a_a] <= d_a;
    if (w_b) mem[a_b] <= d_b;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Issue one command and check every cycle until one idle cycle after it.
  task automatic run_cmd(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [AW:0] l, input logic [DW-1:0] f,
                         input int ign_k, input int rst_k, output int done_k);
    logic [AW-1:0] off, ad;
    logic [DW-1:0] wd, es;
    bit rej, wb_e, busy_e, done_e, err_e, aborted;
    int li, lat, i;
    off = d - s;
    li = int'(l);
    rej = (m == 1'b0) && (li != 0) && (off != 0) && (int'(off) <= li - 1);
    if (rej)          lat = 1;
    else if (li == 0) lat = 1;
    else if (m)       lat = li + 1;
    else              lat = li + 2;
    es = '0;
    done_k = 0;
    aborted = 0;
    mode = m; src = s; dst = d; len = l; fill_val = f; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      busy_e = !rej && (k <= lat);
      done_e = !rej && (k == lat);
      err_e  = rej && (k == 1);
      if (rej || li == 0) begin wb_e = 0; i = 0; end
      else if (m)         begin wb_e = (k <= li); i = k - 1; end
      else                begin wb_e = (k >= 2) && (k <= li + 1); i = k - 2; end
      chk("busy", busy, busy_e);
      chk("done", done, done_e);
      chk("err", err, err_e);
      chk("w_b", w_b, wb_e);
      chk("w_a", w_a, 0);
      chk("d_a", d_a, 0);
      if (done) done_k = k;
      if (!rej && !m && k <= li) chk("a_a", a_a, s + AW'(k - 1));
      if (wb_e) begin
        ad = d + AW'(i);
        wd = m ? f : mdl[s + AW'(i)];
        chk("a_b", a_b, ad);
        chk("d_b", d_b, wd);
        mdl[ad] = wd;
        es ^= wd;
      end
`ifdef RAM_DMA_CSUM_EN
      if (!rej && k >= lat) chk("csum", csum, es);
`endif
      if (!rej && k == rst_k) begin
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_w_b", w_b, 0);
        chk("rst_done", done, 0);
        chk("rst_a_a", a_a, 0);
        chk("rst_a_b", a_b, 0);
        @(negedge clk);
        chk("rst_done2", done, 0);
        chk("rst_w_b2", w_b, 0);
        aborted = 1;
        break;
      end
      if (!rej && k == ign_k) begin
        mode = 1'($urandom); src = 16'($urandom); dst = 16'($urandom);
        len = 17'($urandom_range(1, 9)); fill_val = 16'($urandom); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    end
    for (int j = 0; j < li; j++) begin
      ad = d + AW'(j);
      chk("mem_dst", mem[ad], mdl[ad]);
    end
    if (li < NW) begin
      ad = d + AW'(li);
      chk("mem_next", mem[ad], mdl[ad]);
    end
    chk("mem_src", mem[s], mdl[s]);
    if (aborted) done_k = -1;
  endtask

  initial begin
    int dk, lat, ign, rk;
    logic          rm;
    logic [AW-1:0] rs, rd;
    logic [AW:0]   rl;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_w_b", w_b, 0);
    chk("reset_a_a", a_a, 0);
    chk("reset_a_b", a_b, 0);
    rst = 1'b0;
    @(negedge clk);

    // Whole-memory FILL also gives the RAM and model a known starting image.
    run_cmd(1'b1, 16'h0000, 16'h0000, 17'h10000, 16'h0000, 0, 0, dk);
    chk("lit_full_done", dk, 32'd65537);

    run_cmd(1'b1, 16'h0000, 16'h0010, 17'd4, 16'hBEEF, 0, 0, dk);
    chk("lit_fill_done", dk, 5);
    chk("lit_fill_13", mem[16'h0013], 16'hBEEF);
    chk("lit_fill_14", mem[16'h0014], 16'h0000);

    run_cmd(1'b1, 16'h0000, 16'h0100, 17'd1, 16'd1, 0, 0, dk);
    run_cmd(1'b1, 16'h0000, 16'h0101, 17'd1, 16'd2, 0, 0, dk);
    run_cmd(1'b1, 16'h0000, 16'h0102, 17'd1, 16'd3, 0, 0, dk);
    run_cmd(1'b0, 16'h0100, 16'h0200, 17'd3, 16'h0000, 0, 0, dk);
    chk("lit_copy_done", dk, 5);
    chk("lit_copy_200", mem[16'h0200], 16'd1);
    chk("lit_copy_202", mem[16'h0202], 16'd3);

    run_cmd(1'b1, 16'h0000, 16'hFFFE, 17'd4, 16'h5A5A, 0, 0, dk);
    chk("lit_wrap_ffff", mem[16'hFFFF], 16'h5A5A);
    chk("lit_wrap_0001", mem[16'h0001], 16'h5A5A);
    chk("lit_wrap_0002", mem[16'h0002], 16'h0000);

    run_cmd(1'b0, 16'h0010, 16'h0012, 17'd4, 16'h0000, 0, 0, dk);
    chk("lit_reject_nodone", dk, 0);
    run_cmd(1'b0, 16'h0010, 16'h000E, 17'd4, 16'h0000, 0, 0, dk);
    chk("lit_back_0e", mem[16'h000E], 16'hBEEF);
    run_cmd(1'b0, 16'h0020, 16'h0023, 17'd4, 16'h0000, 0, 0, dk);
    run_cmd(1'b0, 16'h0020, 16'h0024, 17'd4, 16'h0000, 0, 0, dk);
    chk("lit_edge_done", dk, 6);

    run_cmd(1'b0, 16'h0100, 16'h0600, 17'd0, 16'h0000, 1, 0, dk);
    chk("lit_len0_done", dk, 1);
    run_cmd(1'b1, 16'h0000, 16'h0300, 17'd6, 16'h1234, 3, 0, dk);
    chk("lit_ign_done", dk, 7);
    run_cmd(1'b1, 16'h0000, 16'h0310, 17'd2, 16'h4321, 3, 0, dk);

    run_cmd(1'b0, 16'h0100, 16'h0400, 17'd8, 16'h0000, 0, 4, dk);
    chk("lit_abort_402", mem[16'h0402], 16'd3);
    chk("lit_abort_403", mem[16'h0403], 16'd0);
    run_cmd(1'b0, 16'h0200, 16'h0500, 17'd3, 16'h0000, 0, 0, dk);
    chk("lit_fresh_502", mem[16'h0502], 16'd3);

    for (int n = 0; n < 40; n++) begin
      rm = 1'($urandom);
      rs = 16'($urandom_range(0, 63)) + (($urandom % 4 == 0) ? 16'hFFC0 : 16'h0500);
      rd = rs + 16'($urandom_range(0, 40)) - 16'd20;
      rl = 17'($urandom_range(0, 24));
      lat = (rl == 0) ? 1 : (rm ? int'(rl) + 1 : int'(rl) + 2);
      ign = ($urandom % 3 == 0) ? int'($urandom_range(1, lat)) : 0;
      rk  = ($urandom % 8 == 0 && rl >= 2) ? int'($urandom_range(1, int'(rl))) : 0;
      if (ign == rk) ign = 0;
      run_cmd(rm, rs, rd, rl, 16'($urandom), ign, rk, dk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
